// File: rtl/riscv_lsu.sv
// Load/store unit: byte/half/word loads and stores over a single-ported word memory with registered read.
// Define RISCV_LSU_MISALIGN_TRAP_EN to abort misaligned accesses through ERR; otherwise low address bits are ignored.
module riscv_lsu (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_misaligned,
   output logic [31:0] dAddress,
   output logic [31:0] dWriteData,
   input  logic [31:0] dReadData,
   output logic        MemRead,
   output logic        MemWrite
);

`ifdef RISCV_LSU_MISALIGN_TRAP_EN
   typedef enum logic [2:0] {IDLE, READ, MERGE, LDATA, WRITE, ERR} state_t;
`else
   typedef enum logic [2:0] {IDLE, READ, MERGE, LDATA, WRITE} state_t;
`endif

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic        write_q, write_d;
   logic [1:0]  size_q, size_d;
   logic        unsigned_q, unsigned_d;
   logic [31:0] wdata_q, wdata_d;

   logic        req_is_word;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [31:0] load_data;
   logic [31:0] merged_word;
   logic        resp_valid_c;
   logic        mem_read_c;
   logic        mem_write_c;

   assign req_is_word = req_size[1];

   // Lane extraction for loads and read-modify-write merge for sub-word stores.
   always_comb begin
      byte_lane = dReadData[{addr_q[1:0], 3'b000} +: 8];
      half_lane = dReadData[{addr_q[1], 4'b0000} +: 16];
      case (size_q)
         2'd0:    load_data = {{24{byte_lane[7] & ~unsigned_q}}, byte_lane};
         2'd1:    load_data = {{16{half_lane[15] & ~unsigned_q}}, half_lane};
         default: load_data = dReadData;
      endcase
      merged_word = dReadData;
      if (size_q == 2'd0) begin
         merged_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end else begin
         merged_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
   end

   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      write_d         = write_q;
      size_d          = size_q;
      unsigned_d      = unsigned_q;
      wdata_d         = wdata_q;
      req_ready       = 1'b0;
      resp_valid_c    = 1'b0;
      resp_rdata      = 32'h0;
      resp_misaligned = 1'b0;
      mem_read_c      = 1'b0;
      mem_write_c     = 1'b0;
      dAddress        = {addr_q[31:2], 2'b00};
      dWriteData      = 32'h0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            dAddress  = 32'h0;
            if (req_valid) begin
               addr_d     = req_addr;
               write_d    = req_write;
               size_d     = req_size;
               unsigned_d = req_unsigned;
               wdata_d    = req_wdata;
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
               if ((req_size == 2'd1 && req_addr[0]) || (req_is_word && req_addr[1:0] != 2'b00)) begin
                  state_d = ERR;
               end else
`endif
               if (req_write && req_is_word) begin
                  state_d = WRITE;
               end else begin
                  state_d = READ;
               end
            end
         end
         READ: begin
            mem_read_c = 1'b1;
            state_d    = write_q ? MERGE : LDATA;
         end
         LDATA: begin
            resp_valid_c = 1'b1;
            resp_rdata   = load_data;
            state_d      = IDLE;
         end
         MERGE: begin
            wdata_d = merged_word;
            state_d = WRITE;
         end
         WRITE: begin
            mem_write_c  = 1'b1;
            dWriteData   = wdata_q;
            resp_valid_c = 1'b1;
            state_d      = IDLE;
         end
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
         ERR: begin
            resp_valid_c    = 1'b1;
            resp_misaligned = 1'b1;
            state_d         = IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // A reset cycle suppresses strobes and responses so an aborted access leaves no side effect.
   assign resp_valid = resp_valid_c & ~rst;
   assign MemRead    = mem_read_c & ~rst;
   assign MemWrite   = mem_write_c & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         addr_q     <= 32'h0;
         write_q    <= 1'b0;
         size_q     <= 2'd0;
         unsigned_q <= 1'b0;
         wdata_q    <= 32'h0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         write_q    <= write_d;
         size_q     <= size_d;
         unsigned_q <= unsigned_d;
         wdata_q    <= wdata_d;
      end
   end

endmodule

// File: tb/tb_riscv_lsu.sv
// Randomized scoreboard bench for riscv_lsu with a registered-read word memory and an arithmetic reference model.
module tb_riscv_lsu;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_misaligned;
   logic [31:0] dAddress;
   logic [31:0] dWriteData;
   logic [31:0] dReadData;
   logic        MemRead;
   logic        MemWrite;

   riscv_lsu dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_misaligned(resp_misaligned), .dAddress(dAddress), .dWriteData(dWriteData),
      .dReadData(dReadData), .MemRead(MemRead), .MemWrite(MemWrite)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cycle_cnt = 0;
   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   // Device memory seen by the DUT.
   logic        mem_init;
   logic [31:0] bus_mem [0:4095];
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 4096; i++) bus_mem[i] <= (i == 'h800) ? 32'h8899AABB : 32'h0;
      end else if (MemWrite) begin
         bus_mem[dAddress[13:2]] <= dWriteData;
      end
      if (MemRead) dReadData <= bus_mem[dAddress[13:2]];
   end

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [1:0]  sz;
      logic        needs_read;
      logic [31:0] rdata;
      logic        mis;
      logic [31:0] wword;
      int          lat;
      int          start;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] ref_mem [0:4095];
   int          checks = 0;
   int          errors = 0;
   logic        abort_active = 1'b0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, got, want, $time);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      errors++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // Reference model: what the access means architecturally, updating ref_mem for stores.
   task automatic model(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, output exp_t e);
      int          idx;
      int          b;
      int          hb;
      logic [31:0] w;
      logic [31:0] v;
      logic [31:0] mask;
      idx = int'(addr[13:2]);
      b   = int'(addr[1:0]);
      hb  = addr[1] ? 2 : 0;
      w   = ref_mem[idx];
      e.addr  = addr;
      e.wr    = wr;
      e.sz    = sz;
      e.rdata = 32'h0;
      e.mis   = 1'b0;
      e.wword = 32'h0;
      e.lat   = 1;
      e.start = 0;
      e.needs_read = !(wr && sz[1]);
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
      if ((sz == 2'd1 && addr[0]) || (sz[1] && addr[1:0] != 2'b00)) begin
         e.mis = 1'b1;
         e.needs_read = 1'b0;
      end else
`endif
      if (!wr) begin
         e.lat = 2;
         if (sz == 2'd0) begin
            v = (w >> (8 * b)) & 32'hFF;
            if (!uns && v[7]) v = v | 32'hFFFFFF00;
         end else if (sz == 2'd1) begin
            v = (w >> (8 * hb)) & 32'hFFFF;
            if (!uns && v[15]) v = v | 32'hFFFF0000;
         end else begin
            v = w;
         end
         e.rdata = v;
      end else begin
         if (sz == 2'd0) begin
            mask = 32'hFF << (8 * b);
            w = (w & ~mask) | ((wd & 32'hFF) << (8 * b));
            e.lat = 3;
         end else if (sz == 2'd1) begin
            mask = 32'hFFFF << (8 * hb);
            w = (w & ~mask) | ((wd & 32'hFFFF) << (8 * hb));
            e.lat = 3;
         end else begin
            w = wd;
            e.lat = 1;
         end
         ref_mem[idx] = w;
         e.wword = w;
      end
   endtask

   task automatic wait_ready();
      int w = 0;
      @(negedge clk);
      while (!req_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!req_ready) flag("ready_timeout");
   endtask

   task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic use_lit, input logic [31:0] lit);
      exp_t e;
      wait_ready();
      model(wr, sz, uns, addr, wd, e);
      if (use_lit) e.rdata = lit;
      e.start = cycle_cnt;
      exp_q.push_back(e);
      req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
      req_addr = addr; req_wdata = wd;
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic monitor();
      exp_t f;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (MemRead && MemWrite) flag("both_strobes");
            if (!MemWrite && dWriteData !== 32'h0) flag("wdata_outside_write");
            if (!resp_valid && resp_misaligned) flag("misaligned_without_valid");
            if (abort_active) begin
               if (MemWrite) flag("abort_memwrite");
               if (MemRead) chk("abort_daddr", dAddress, 32'h2000);
            end else if (MemRead || MemWrite) begin
               if (exp_q.size() == 0) begin
                  flag("strobe_without_request");
               end else begin
                  f = exp_q[0];
                  chk("daddr", dAddress, {f.addr[31:2], 2'b00});
                  if (MemRead) begin
                     if (!f.needs_read) flag("unexpected_memread");
                     chk("memread_cycle", cycle_cnt - f.start, 1);
                  end
                  if (MemWrite) begin
                     if (!f.wr || f.mis) flag("unexpected_memwrite");
                     chk("memwrite_cycle", cycle_cnt - f.start, f.lat);
                     chk("dwritedata", dWriteData, f.wword);
                  end
               end
            end
            if (resp_valid) begin
               if (exp_q.size() == 0) begin
                  flag("unexpected_resp");
               end else begin
                  f = exp_q.pop_front();
                  $display("txn wr=%0d size=%0d addr=%h rdata=%h mis=%0d lat=%0d",
                           f.wr, f.sz, f.addr, resp_rdata, resp_misaligned, cycle_cnt - f.start);
                  chk("resp_rdata", resp_rdata, f.rdata);
                  chk("resp_misaligned", {31'h0, resp_misaligned}, {31'h0, f.mis});
                  chk("resp_latency", cycle_cnt - f.start, f.lat);
               end
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; mem_init = 1'b1; req_valid = 1'b0; req_write = 1'b0;
      req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      for (int i = 0; i < 4096; i++) ref_mem[i] = 32'h0;
      ref_mem['h800] = 32'h8899AABB;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0; mem_init = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
      chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
      chk("rst_resp_mis", {31'h0, resp_misaligned}, 32'h0);
      chk("rst_memread", {31'h0, MemRead}, 32'h0);
      chk("rst_memwrite", {31'h0, MemWrite}, 32'h0);
      chk("rst_resp_rdata", resp_rdata, 32'h0);
      chk("rst_daddress", dAddress, 32'h0);
      chk("rst_dwritedata", dWriteData, 32'h0);

      fork
         monitor();
      join_none

      issue(1'b0, 2'd0, 1'b0, 32'h2001, 32'h0, 1'b1, 32'hFFFFFFAA);
      issue(1'b0, 2'd1, 1'b1, 32'h2002, 32'h0, 1'b1, 32'h00008899);
      issue(1'b0, 2'd0, 1'b1, 32'h2000, 32'h0, 1'b1, 32'h000000BB);
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
      issue(1'b0, 2'd2, 1'b0, 32'h2002, 32'h0, 1'b1, 32'h0);
`else
      issue(1'b0, 2'd2, 1'b0, 32'h2002, 32'h0, 1'b1, 32'h8899AABB);
`endif
      issue(1'b1, 2'd0, 1'b0, 32'h2003, 32'h0000005A, 1'b1, 32'h0);
      issue(1'b0, 2'd2, 1'b0, 32'h2000, 32'h0, 1'b1, 32'h5A99AABB);
      issue(1'b1, 2'd2, 1'b0, 32'h2004, 32'hDEADBEEF, 1'b1, 32'h0);
      issue(1'b0, 2'd2, 1'b0, 32'h2004, 32'h0, 1'b1, 32'hDEADBEEF);

      // sh aborted by reset while in MERGE
      wait_ready();
      abort_active = 1'b1;
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
      req_addr = 32'h2000; req_wdata = 32'h00001234;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("abort_merge_resp_valid", {31'h0, resp_valid}, 32'h0);
      chk("abort_merge_memwrite", {31'h0, MemWrite}, 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_req_ready", {31'h0, req_ready}, 32'h1);
      chk("abort_after_memwrite", {31'h0, MemWrite}, 32'h0);
      chk("abort_after_resp_valid", {31'h0, resp_valid}, 32'h0);
      @(negedge clk);
      chk("abort_late_memwrite", {31'h0, MemWrite}, 32'h0);
      abort_active = 1'b0;
      chk("abort_mem_unchanged", bus_mem['h800], 32'h5A99AABB);

      for (int n = 0; n < 150; n++) begin
         issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               32'h2000 + 32'($urandom_range(0, 63)), $urandom, 1'b0, 32'h0);
      end

      begin
         int w = 0;
         while (exp_q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
         end
         if (exp_q.size() != 0) flag("drain_timeout");
      end
      @(negedge clk);
      for (int i = 'h800; i < 'h810; i++) chk("mem_final", bus_mem[i], ref_mem[i]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
